// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: drives ROM address, buffers {inst,pc} in a small FIFO, presents it to decode.
// Word fetched in cycle N is valid to decode in N+1; Dec_Ready low holds the head, and a full FIFO freezes the PC.
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          ROM_WORDS = 32,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   output logic [31:0] Imem_Addr,
   input  logic [31:0] Imem_Inst,
   output logic        Dec_Valid,
   input  logic        Dec_Ready,
   output logic [31:0] Dec_Inst,
   output logic [31:0] Dec_PC,
   input  logic        Redirect,
   input  logic [31:0] Redirect_PC,
   output logic        Fetch_Err
);

   localparam int          PW        = $clog2(BUF_DEPTH);
   localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);
   localparam logic [PW:0] FULL      = (PW + 1)'(BUF_DEPTH);

   logic [31:0]   fetch_pc;
   logic          fetch_err;
   logic [PW:0]   count;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [31:0]   inst_q [BUF_DEPTH];
   logic [31:0]   pc_q   [BUF_DEPTH];

   logic inrange;
   logic deq;
   logic enq;
   logic unused_ok;

   assign unused_ok = ^Redirect_PC[1:0];

   assign inrange   = (fetch_pc < ROM_BYTES);
   assign Dec_Valid = (count != '0) & ~Redirect;
   assign deq       = Dec_Valid & Dec_Ready;
   // a full FIFO can still take a word when the head leaves in the same cycle
   assign enq       = ~Redirect & inrange & ~fetch_err & ((count != FULL) | deq);

   assign Imem_Addr = fetch_pc;
   assign Dec_Inst  = inst_q[head];
   assign Dec_PC    = pc_q[head];
   assign Fetch_Err = fetch_err;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         fetch_pc  <= RESET_PC;
         fetch_err <= 1'b0;
         count     <= '0;
         head      <= '0;
         tail      <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else if (Redirect) begin
         fetch_pc  <= {Redirect_PC[31:2], 2'b00};
         fetch_err <= 1'b0;
         count     <= '0;
         head      <= '0;
         tail      <= '0;
      end else begin
         if (enq) begin
            inst_q[tail] <= Imem_Inst;
            pc_q[tail]   <= fetch_pc;
            tail         <= tail + 1'b1;
            fetch_pc     <= fetch_pc + 32'd4;
         end
         if (deq)
            head <= head + 1'b1;
         if (enq && !deq)
            count <= count + 1'b1;
         else if (!enq && deq)
            count <= count - 1'b1;
         // sticky until the next redirect or reset
         if (!inrange)
            fetch_err <= 1'b1;
      end
   end

endmodule
